ysyx_23060072_hazard_ctrl: RTL

- Producer side of the pipeline bypass scheme: decides when results cannot be forwarded and drives stall, bubble and flush controls into the IF/ID/EX/LSU/WB pipeline registers.
- Detects load-use hazards between the ID-stage instruction and a load in EX, and freezes the pipeline during multi-cycle LSU accesses.
- Kills wrong-path instructions on an EX redirect and flags LSU timeouts.
- Sits beside the forwarding unit, between decode and the pipeline registers.

---
 rtl/ysyx_23060072_hazard_ctrl_pkg.sv | 12 +
 rtl/ysyx_23060072_hazard_ctrl_sat_counter.sv | 29 ++
 rtl/ysyx_23060072_hazard_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ysyx_23060072_hazard_ctrl_pkg.sv
// Shared constants for the hazard controller: FSM encodings, default register
// address width and the hard-wired zero register address.
package ysyx_23060072_hazard_ctrl_pkg;

  localparam logic STATE_RUN      = 1'b0;
  localparam logic STATE_LSU_WAIT = 1'b1;

  localparam int REG_AW_DEF = 5;

  localparam logic [REG_AW_DEF-1:0] X0_ADDR = '0;

endpackage

// File: rtl/ysyx_23060072_hazard_ctrl_sat_counter.sv
// Up-counter that saturates at all-ones; synchronous clear wins over enable.
module ysyx_23060072_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_23060072_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, LSU wait freeze, redirect flush
// and sticky LSU timeout. Define YSYX_23060072_HAZARD_PERF_EN for perf counters.
module ysyx_23060072_hazard_ctrl
  import ysyx_23060072_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int LSU_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_has_rs1,
  input  logic              id_has_rs2,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic              id_store_flag,
  input  logic              ex_valid,
  input  logic              ex_load_flag,
  input  logic [REG_AW-1:0] ex_wb_addr,
  input  logic              ex_redirect,
  input  logic              lsu_req_valid,
  input  logic              lsu_resp_valid,
  output logic              pc_stall,
  output logic              if2id_stall,
  output logic              if2id_flush,
  output logic              id2ex_stall,
  output logic              id2ex_bubble,
  output logic              ex2lsu_stall,
  output logic              lsu2wb_bubble,
  output logic              lsu_timeout_err,
`ifdef YSYX_23060072_HAZARD_PERF_EN
  output logic [CNT_W-1:0]  perf_lu_stall_cnt,
  output logic [CNT_W-1:0]  perf_lsu_wait_cnt,
  output logic [CNT_W-1:0]  perf_flush_cnt,
`endif
  output logic              dbg_state_o
);

  localparam logic             TO_EN   = (LSU_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((LSU_TIMEOUT == 0) ? 0 : LSU_TIMEOUT - 1);

  logic             state_q;
  logic             state_d;
  logic             err_q;
  logic             err_d;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             load_use;
  logic             lu_stall;
  logic             in_wait;
  logic             to_hit;
  logic [CNT_W-1:0] to_cnt;

  // A store's rs2 is data only; the LSU-stage bypass covers it.
  assign rs1_hit  = id_has_rs1 && (id_rs1_addr == ex_wb_addr);
  assign rs2_hit  = id_has_rs2 && (id_rs2_addr == ex_wb_addr) && !id_store_flag;
  assign load_use = ex_valid && ex_load_flag && (ex_wb_addr != REG_AW'(X0_ADDR))
                    && id_valid && (rs1_hit || rs2_hit);

  assign in_wait  = (state_q == STATE_LSU_WAIT);
  assign lu_stall = !in_wait && load_use && !ex_redirect;

  always_comb begin
    state_d       = state_q;
    pc_stall      = 1'b0;
    if2id_stall   = 1'b0;
    if2id_flush   = 1'b0;
    id2ex_stall   = 1'b0;
    id2ex_bubble  = 1'b0;
    ex2lsu_stall  = 1'b0;
    lsu2wb_bubble = 1'b0;
    if (state_q == STATE_RUN) begin
      if (lsu_req_valid && !lsu_resp_valid) begin
        state_d = STATE_LSU_WAIT;
      end
      // Redirect discards the younger instructions, so it beats load-use.
      if (ex_redirect) begin
        if2id_flush  = 1'b1;
        id2ex_bubble = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if2id_stall  = 1'b1;
        id2ex_bubble = 1'b1;
      end
    end else begin
      if (lsu_resp_valid) begin
        state_d = STATE_RUN;
      end else begin
        pc_stall      = 1'b1;
        if2id_stall   = 1'b1;
        id2ex_stall   = 1'b1;
        ex2lsu_stall  = 1'b1;
        lsu2wb_bubble = 1'b1;
      end
    end
  end

  ysyx_23060072_sat_counter #(.W(CNT_W)) u_timeout_cnt (
    .clk_i (clk),
    .clr_i (rst || (state_d == STATE_RUN)),
    .en_i  (in_wait),
    .cnt_o (to_cnt)
  );

  assign to_hit = TO_EN && in_wait && !lsu_resp_valid && (to_cnt == TO_LAST);
  assign err_d  = err_q || to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STATE_RUN;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign lsu_timeout_err = err_q;
  assign dbg_state_o     = state_q;

`ifdef YSYX_23060072_HAZARD_PERF_EN
  ysyx_23060072_sat_counter #(.W(CNT_W)) u_perf_lu (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (lu_stall),
    .cnt_o (perf_lu_stall_cnt)
  );

  ysyx_23060072_sat_counter #(.W(CNT_W)) u_perf_wait (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (in_wait),
    .cnt_o (perf_lsu_wait_cnt)
  );

  ysyx_23060072_sat_counter #(.W(CNT_W)) u_perf_flush (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (if2id_flush),
    .cnt_o (perf_flush_cnt)
  );
`else
  logic unused_lu;
  assign unused_lu = lu_stall;
`endif

endmodule
